// File: rtl/bd_merge_arbiter.sv
// bd_merge_arbiter: N-input round-robin merge with bounded burst lock,
// per-input enable mask and a single registered output slot. Each output
// word carries {source index, payload}.
// Optional feature macro: MERGE_STATS_EN adds per-input saturating
// accepted-word counters on stat_count; without it stat_count is 0.
module bd_merge_arbiter #(
  parameter int unsigned NIN       = 4,
  parameter int unsigned NDATA     = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned NSRC     = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NIN-1:0]         in_v,
  input  logic [NIN*NDATA-1:0]   in_d,
  output logic [NIN-1:0]         in_a,
  input  logic [NIN-1:0]         in_en,
  output logic                   out_v,
  output logic [NSRC+NDATA-1:0]  out_d,
  input  logic                   out_a,
  input  logic                   stat_clear,
  output logic [NIN*16-1:0]      stat_count
);

  localparam int unsigned CW = 8;

  typedef enum logic [0:0] {S_IDLE, S_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [NSRC-1:0]         hold_q, hold_d;
  logic [NSRC-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    out_v_q;
  logic [NSRC+NDATA-1:0]   out_d_q;

  logic [NIN-1:0]          elig;
  logic                    slot_free;
  logic                    held_ok;
  logic                    hi_found;
  logic [NSRC-1:0]         hi_idx, lo_idx, rr_idx, next_ptr;
  logic                    grant;
  logic [NSRC-1:0]         grant_idx;
  logic [NDATA-1:0]        grant_data;
  logic [NIN-1:0]          in_a_c;

  assign elig      = in_v & in_en;
  assign slot_free = !out_v_q || out_a;

  // Round-robin pick: lowest eligible index at or above ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NIN - 1; k >= 0; k--) begin
      if (elig[k]) begin
        lo_idx = NSRC'(k);
        if (NSRC'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = NSRC'(k);
        end
      end
    end
    rr_idx   = hi_found ? hi_idx : lo_idx;
    next_ptr = (rr_idx == NSRC'(NIN - 1)) ? '0 : rr_idx + NSRC'(1);
  end

  // Whether the currently held input is still valid and enabled.
  always_comb begin
    held_ok = 1'b0;
    for (int k = 0; k < NIN; k++) begin
      if (hold_q == NSRC'(k)) held_ok = elig[k];
    end
  end

  // Grant decision and next-state; everything frozen while the slot is full.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_idx = hold_q;
    if (slot_free && reset) begin
      if (state_q == S_HOLD && held_ok && cnt_q < CW'(MAX_BURST)) begin
        grant = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end else if (|elig) begin
        grant     = 1'b1;
        grant_idx = rr_idx;
        hold_d    = rr_idx;
        ptr_d     = next_ptr;
        cnt_d     = CW'(1);
        state_d   = S_HOLD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Payload mux and one-hot acknowledge for the granted input.
  always_comb begin
    grant_data = '0;
    in_a_c     = '0;
    for (int k = 0; k < NIN; k++) begin
      if (grant_idx == NSRC'(k)) begin
        grant_data = in_d[k*NDATA +: NDATA];
        in_a_c[k]  = grant;
      end
    end
  end

  assign in_a = in_a_c;

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output slot: load on grant, drain on acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q <= 1'b0;
      out_d_q <= '0;
    end else if (grant) begin
      out_v_q <= 1'b1;
      out_d_q <= {grant_idx, grant_data};
    end else if (out_a) begin
      out_v_q <= 1'b0;
    end
  end

  assign out_v = out_v_q;
  assign out_d = out_d_q;

`ifdef MERGE_STATS_EN
  logic [NIN-1:0][15:0] stat_q;

  // Saturating per-input accepted-word counters; clear has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < NIN; k++) begin
        if (stat_clear) begin
          stat_q[k] <= '0;
        end else if (in_v[k] && in_a_c[k] && stat_q[k] != 16'hFFFF) begin
          stat_q[k] <= stat_q[k] + 16'd1;
        end
      end
    end
  end

  assign stat_count = stat_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_count        = '0;
`endif

endmodule

// File: tb/tb_bd_merge_arbiter.sv
// Directed self-checking bench for bd_merge_arbiter (NIN=4, NDATA=32, MAX_BURST=4).
module tb_bd_merge_arbiter;

  localparam int unsigned NIN   = 4;
  localparam int unsigned NDATA = 32;
  localparam int unsigned NSRC  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NIN-1:0]        in_v;
  logic [NIN*NDATA-1:0]  in_d;
  logic [NIN-1:0]        in_a;
  logic [NIN-1:0]        in_en;
  logic                  out_v;
  logic [NSRC+NDATA-1:0] out_d;
  logic                  out_a;
  logic                  stat_clear;
  logic [NIN*16-1:0]     stat_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bd_merge_arbiter #(.NIN(NIN), .NDATA(NDATA), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_v       (in_v),
    .in_d       (in_d),
    .in_a       (in_a),
    .in_en      (in_en),
    .out_v      (out_v),
    .out_d      (out_d),
    .out_a      (out_a),
    .stat_clear (stat_clear),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1);
  end

  task automatic do_reset();
    reset      = 1'b0;
    in_v       = '0;
    in_d       = '0;
    in_en      = 4'b1111;
    out_a      = 1'b0;
    stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_v = 4'b1111; in_en = 4'b1111; out_a = 1'b1;
    in_d = '1; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b want 0", out_v); else pass_cnt++;
    total_cnt++;
    if (out_d !== '0) $display("FAIL reset_out_d: got %h want 0", out_d); else pass_cnt++;
    total_cnt++;
    if (in_a !== 4'b0000) $display("FAIL reset_in_a: got %b want 0000", in_a); else pass_cnt++;
    total_cnt++;
    if (stat_count !== '0) $display("FAIL reset_stat: got %h want 0", stat_count); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    in_d[2*NDATA +: NDATA] = 32'hDEADBEEF;
    in_v = 4'b0100; out_a = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0100) $display("FAIL single_in_a: got %b want 0100", in_a); else pass_cnt++;
    total_cnt++;
    if (out_v !== 1'b0) $display("FAIL single_latency: got out_v %b want 0", out_v); else pass_cnt++;
    @(posedge clk); #1 in_v = 4'b0000;
    total_cnt++;
    if (out_v !== 1'b1) $display("FAIL single_out_v: got %b want 1", out_v); else pass_cnt++;
    total_cnt++;
    if (out_d !== {2'd2, 32'hDEADBEEF}) $display("FAIL single_out_d: got %h want %h", out_d, {2'd2, 32'hDEADBEEF}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_v !== 1'b0) $display("FAIL single_drain: got out_v %b want 0", out_v); else pass_cnt++;
  endtask

  task automatic test_burst();
    int seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [3:0]            exp_a;
    logic [NSRC+NDATA-1:0] exp_d;
    do_reset();
    for (int k = 0; k < NIN; k++) in_d[k*NDATA +: NDATA] = 32'hA000_0000 + 32'(k);
    in_v = 4'b0011; out_a = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_a = 4'b0001 << seq[c];
      exp_d = {NSRC'(seq[c]), 32'hA000_0000 + 32'(seq[c])};
      @(negedge clk);
      total_cnt++;
      if (in_a !== exp_a) $display("FAIL burst_in_a[%0d]: got %b want %b", c, in_a, exp_a); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_d !== exp_d) $display("FAIL burst_out_d[%0d]: got %h want %h", c, out_d, exp_d); else pass_cnt++;
    end
    in_v = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_d[0 +: NDATA] = 32'h0000_00A0;
    in_v = 4'b0001; out_a = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0001) $display("FAIL bp_first_in_a: got %b want 0001", in_a); else pass_cnt++;
    @(posedge clk); #1 in_d[0 +: NDATA] = 32'h0000_00A1;
    total_cnt++;
    if (out_d !== {2'd0, 32'h0000_00A0}) $display("FAIL bp_first_out_d: got %h want %h", out_d, {2'd0, 32'h0000_00A0}); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total_cnt++;
      if (in_a !== 4'b0000) $display("FAIL bp_stall_in_a[%0d]: got %b want 0000", c, in_a); else pass_cnt++;
      total_cnt++;
      if (out_d !== {2'd0, 32'h0000_00A0} || out_v !== 1'b1)
        $display("FAIL bp_stall_out[%0d]: got v=%b d=%h want v=1 d=%h", c, out_v, out_d, {2'd0, 32'h0000_00A0});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_a = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0001) $display("FAIL bp_resume_in_a: got %b want 0001", in_a); else pass_cnt++;
    @(posedge clk); #1 in_v = 4'b0000;
    total_cnt++;
    if (out_d !== {2'd0, 32'h0000_00A1}) $display("FAIL bp_resume_out_d: got %h want %h", out_d, {2'd0, 32'h0000_00A1}); else pass_cnt++;
  endtask

  task automatic test_mask();
    int seq [10] = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1};
    logic [3:0] exp_a;
    do_reset();
    for (int k = 0; k < NIN; k++) in_d[k*NDATA +: NDATA] = 32'hB000_0000 + 32'(k);
    in_v = 4'b1111; in_en = 4'b1010; out_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) in_en = 4'b0010;
      exp_a = 4'b0001 << seq[c];
      @(negedge clk);
      total_cnt++;
      if (in_a !== exp_a) $display("FAIL mask_in_a[%0d]: got %b want %b", c, in_a, exp_a); else pass_cnt++;
      @(posedge clk); #1;
    end
    in_v = 4'b0000; in_en = 4'b1111;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_d[2*NDATA +: NDATA] = 32'h0000_00C2;
    in_d[3*NDATA +: NDATA] = 32'h0000_00C3;
    in_v = 4'b0100; out_a = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0100) $display("FAIL rmid_first: got %b want 0100", in_a); else pass_cnt++;
    @(posedge clk); #1 in_v = 4'b1100;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0100) $display("FAIL rmid_hold: got %b want 0100", in_a); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_v !== 1'b1) $display("FAIL rmid_pre_v: got %b want 1", out_v); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (out_v !== 1'b0) $display("FAIL rmid_out_v: got %b want 0", out_v); else pass_cnt++;
    total_cnt++;
    if (in_a !== 4'b0000) $display("FAIL rmid_in_a: got %b want 0000", in_a); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (in_a !== 4'b0000) $display("FAIL rmid_in_a_held: got %b want 0000", in_a); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_a !== 4'b0100) $display("FAIL rmid_ptr_zero: got %b want 0100", in_a); else pass_cnt++;
    @(posedge clk); #1 in_v = 4'b0000;
    total_cnt++;
    if (out_d !== {2'd2, 32'h0000_00C2}) $display("FAIL rmid_out_d: got %h want %h", out_d, {2'd2, 32'h0000_00C2}); else pass_cnt++;
  endtask

  task automatic test_stats();
    do_reset();
    in_d[0 +: NDATA] = 32'h1234_5678;
    in_v = 4'b0001; out_a = 1'b1;
`ifdef MERGE_STATS_EN
    repeat (70000) @(posedge clk);
    #1 in_v = 4'b0000;
    total_cnt++;
    if (stat_count[15:0] !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", stat_count[15:0]); else pass_cnt++;
    total_cnt++;
    if (stat_count[63:16] !== '0) $display("FAIL stats_others: got %h want 0", stat_count[63:16]); else pass_cnt++;
    stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    total_cnt++;
    if (stat_count !== '0) $display("FAIL stats_clear: got %h want 0", stat_count); else pass_cnt++;
`else
    repeat (20) @(posedge clk);
    #1 in_v = 4'b0000;
    total_cnt++;
    if (stat_count !== '0) $display("FAIL stats_off: got %h want 0", stat_count); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
